// File: rtl/load_store_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit_if : core request/response and memory port bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_error_o;
  logic [31:0] mem_address_o;
  logic        mem_write_enable_o;
  logic [31:0] mem_write_data_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  resp_ready_i, mem_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o,
    output mem_address_o, mem_write_enable_o, mem_write_data_o
  );

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output resp_ready_i, mem_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o,
    input  mem_address_o, mem_write_enable_o, mem_write_data_o
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : byte/half/word loads and stores, sub-word stores by RMW
// Revision: 1.0
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        ready;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;

  logic        cap_write;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        exec;
  logic        write_en;

  // Fault check is made on the live request so errors can skip EXEC.
  always_comb begin
    req_err = (bus.req_size_i == 2'b11)
            | ((bus.req_size_i == 2'b01) & bus.req_addr_i[0])
            | ((bus.req_size_i == 2'b10) & (bus.req_addr_i[1:0] != 2'b00))
            | ({1'b0, bus.req_addr_i} >= ADDR_LIMIT);
  end

  always_comb begin
    lane_byte = bus.mem_data_i[7:0];
    case (cap_addr[1:0])
      2'd0:    lane_byte = bus.mem_data_i[7:0];
      2'd1:    lane_byte = bus.mem_data_i[15:8];
      2'd2:    lane_byte = bus.mem_data_i[23:16];
      default: lane_byte = bus.mem_data_i[31:24];
    endcase
    lane_half = cap_addr[1] ? bus.mem_data_i[31:16] : bus.mem_data_i[15:0];

    load_val = bus.mem_data_i;
    merged   = bus.mem_data_i;
    case (cap_size)
      2'b00: begin
        load_val = cap_unsigned ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        case (cap_addr[1:0])
          2'd0:    merged[7:0]   = cap_wdata[7:0];
          2'd1:    merged[15:8]  = cap_wdata[7:0];
          2'd2:    merged[23:16] = cap_wdata[7:0];
          default: merged[31:24] = cap_wdata[7:0];
        endcase
      end
      2'b01: begin
        load_val = cap_unsigned ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
        if (cap_addr[1]) merged[31:16] = cap_wdata[15:0];
        else             merged[15:0]  = cap_wdata[15:0];
      end
      default: begin
        load_val = bus.mem_data_i;
        merged   = cap_wdata;
      end
    endcase
  end

  // Memory port is decoded from state so reset silences it without waiting for a clock.
  assign exec                   = (state == EXEC);
  assign write_en               = exec & cap_write;
  assign bus.mem_address_o      = exec ? {2'b00, cap_addr[31:2]} : 32'd0;
  assign bus.mem_write_enable_o = write_en;
  assign bus.mem_write_data_o   = write_en ? merged : 32'd0;

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_error_o = resp_error;
  assign bus.resp_rdata_o = resp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= 32'd0;
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (bus.req_valid_i && ready) begin
            ready        <= 1'b0;
            cap_write    <= bus.req_write_i;
            cap_size     <= bus.req_size_i;
            cap_unsigned <= bus.req_unsigned_i;
            cap_addr     <= bus.req_addr_i;
            cap_wdata    <= bus.req_wdata_i;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= cap_write ? 32'd0 : load_val;
        end
        RESP: begin
          // ready rises with the return to IDLE, so no accept in the consume cycle.
          if (bus.resp_ready_i) begin
            state      <= IDLE;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit : randomized and directed checks against a byte-array model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;
  localparam int MW = 256;
  localparam int AW = $clog2(MW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_count = 0;
  int   cyc = 0;
  int   acc_q[$];

  logic [31:0] tb_mem [MW];
  logic [7:0]  ref_mem [MW*4];

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data_i = tb_mem[bus.mem_address_o[AW-1:0]];

  always @(posedge clk) begin
    if (bus.mem_write_enable_o) tb_mem[bus.mem_address_o[AW-1:0]] <= bus.mem_write_data_o;
    if (bus.req_valid_i && bus.req_ready_o) acc_q.push_back(cyc);
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (bus.mem_write_enable_o) wr_count++;
    else begin
      n_cmp++;
      if (bus.mem_write_data_o !== 32'd0) begin
        n_bad++;
        $display("FAIL idle_wdata: got %h want 0", bus.mem_write_data_o);
      end
    end
  end

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  // Reference: flat byte-addressed memory, sizes as byte counts.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic un,
                                input logic [31:0] ad, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    e = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0) ||
        ({32'd0, ad} >= 64'(MW*4));
    rd = 32'd0;
    if (e) return;
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[ad+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ad+i];
      if (!un && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endfunction

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          wc0;
    int          guard;
    model(wr, sz, un, ad, wd, exp_err, exp_rd);
    wc0 = wr_count;
    bus.resp_ready_i   = 1'b0;
    bus.req_write_i    = wr;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = un;
    bus.req_addr_i     = ad;
    bus.req_wdata_i    = wd;
    bus.req_valid_i    = 1'b1;
    guard = 0;
    while (!bus.req_ready_o && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_bad++;
      $display("FAIL accept_timeout: req_ready_o=%b want 1", bus.req_ready_o);
    end
    @(posedge clk); #1;
    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'($urandom);
    bus.req_size_i     = 2'($urandom);
    bus.req_addr_i     = $urandom;
    bus.req_wdata_i    = $urandom;
    lat = 1;
    while (!bus.resp_valid_o && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    rd = bus.resp_rdata_o;
    er = bus.resp_error_o;
    n_cmp++;
    if (lat !== (exp_err ? 1 : 2)) begin
      n_bad++;
      $display("FAIL latency: got %0d want %0d (addr %h size %0d)", lat, exp_err ? 1 : 2, ad, sz);
    end
    n_cmp++;
    if (er !== exp_err) begin
      n_bad++;
      $display("FAIL error: got %b want %b (addr %h size %0d)", er, exp_err, ad, sz);
    end
    n_cmp++;
    if (rd !== exp_rd) begin
      n_bad++;
      $display("FAIL rdata: got %h want %h (addr %h size %0d un %b wr %b)", rd, exp_rd, ad, sz, un, wr);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.resp_valid_o, bus.resp_error_o, bus.resp_rdata_o, bus.req_ready_o} !== {1'b1, er, rd, 1'b0}) begin
        n_bad++;
        $display("FAIL hold: got v=%b e=%b d=%h rdy=%b want v=1 e=%b d=%h rdy=0",
                 bus.resp_valid_o, bus.resp_error_o, bus.resp_rdata_o, bus.req_ready_o, er, rd);
      end
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    n_cmp++;
    if ({bus.resp_valid_o, bus.req_ready_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL release: got valid=%b ready=%b want valid=0 ready=1", bus.resp_valid_o, bus.req_ready_o);
    end
    n_cmp++;
    if (wr_count - wc0 !== ((wr && !exp_err) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL write_count: got %0d want %0d", wr_count - wc0, (wr && !exp_err) ? 1 : 0);
    end
    if (!exp_err) begin
      n_cmp++;
      if (tb_mem[ad[AW+1:2]] !== ref_word(int'(ad[AW+1:2]))) begin
        n_bad++;
        $display("FAIL mem_word: got %h want %h at word %0d", tb_mem[ad[AW+1:2]], ref_word(int'(ad[AW+1:2])), ad[AW+1:2]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_error_o, bus.resp_rdata_o,
         bus.mem_address_o, bus.mem_write_enable_o, bus.mem_write_data_o} !== 99'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b v=%b e=%b d=%h a=%h we=%b wd=%h want all 0",
               bus.req_ready_o, bus.resp_valid_o, bus.resp_error_o, bus.resp_rdata_o,
               bus.mem_address_o, bus.mem_write_enable_o, bus.mem_write_data_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.req_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready_held: got %b want 0", bus.req_ready_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.req_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b want 1", bus.req_ready_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hFFFFFFDE || lat !== 2) begin
      n_bad++;
      $display("FAIL signed_byte_load: got %h lat %0d want FFFFFFDE lat 2", rd, lat);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 1, rd, er, lat);
    n_cmp++;
    if (tb_mem[4] !== 32'h1234BEEF) begin
      n_bad++;
      $display("FAIL half_rmw: got %h want 1234BEEF", tb_mem[4]);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0000BEEF) begin
      n_bad++;
      $display("FAIL unsigned_half_load: got %h want 0000BEEF", rd);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0, rd, er, lat);
    do_req(1'b1, 2'd0, 1'b0, 32'h3FF, $urandom, 0, rd, er, lat);
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] addrs [4] = '{32'h02, 32'h01, 32'h400, 32'h08};
    logic [1:0]  sizes [4] = '{2'd2, 2'd1, 2'd2, 2'd3};
    logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_req(wrs[i], sizes[i], 1'b0, addrs[i], $urandom, 0, rd, er, lat);
      n_cmp++;
      if ({er, rd} !== {1'b1, 32'd0} || lat !== 1) begin
        n_bad++;
        $display("FAIL error_case_%0d: got e=%b d=%h lat %0d want e=1 d=0 lat 1", i, er, rd, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5, rd, er, lat);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5, rd, er, lat);
  endtask

  task automatic test_reset_abort();
    logic [31:0] ad;
    logic [31:0] saved;
    int          wc0;
    ad = 32'($urandom_range(0, MW*4-1));
    bus.resp_ready_i   = 1'b0;
    bus.req_write_i    = 1'b1;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = ad;
    bus.req_wdata_i    = ~{4{ref_mem[ad]}};
    bus.req_valid_i    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    saved = tb_mem[ad[AW+1:2]];
    n_cmp++;
    if (bus.mem_write_enable_o !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_exec_we: got %b want 1", bus.mem_write_enable_o);
    end
    wc0 = wr_count;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_write_enable_o, bus.mem_address_o, bus.resp_valid_o, bus.req_ready_o} !== 35'd0) begin
      n_bad++;
      $display("FAIL abort_outputs: we=%b a=%h v=%b rdy=%b want all 0",
               bus.mem_write_enable_o, bus.mem_address_o, bus.resp_valid_o, bus.req_ready_o);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.resp_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_resp: got %b want 0", bus.resp_valid_o);
      end
    end
    n_cmp++;
    if (tb_mem[ad[AW+1:2]] !== saved || saved !== ref_word(int'(ad[AW+1:2])) || wr_count !== wc0) begin
      n_bad++;
      $display("FAIL abort_mem: got %h writes %0d want %h writes 0", tb_mem[ad[AW+1:2]], wr_count - wc0, ref_word(int'(ad[AW+1:2])));
    end
  endtask

  task automatic test_back_to_back(input logic [1:0] sz, input int spacing);
    acc_q.delete();
    bus.resp_ready_i   = 1'b1;
    bus.req_write_i    = 1'b0;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = 1'($urandom);
    bus.req_addr_i     = 32'($urandom_range(0, MW-1)) << 2;
    bus.req_valid_i    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    bus.resp_ready_i = 1'b0;
    n_cmp++;
    if (acc_q.size() < 5 || bus.req_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d accepts ready=%b want >=5 ready=1", acc_q.size(), bus.req_ready_o);
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      n_cmp++;
      if (acc_q[i] - acc_q[i-1] !== spacing) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d want %0d", acc_q[i] - acc_q[i-1], spacing);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [1:0]  sz;
    logic [31:0] ad;
    for (int k = 0; k < 150; k++) begin
      sz = 2'($urandom);
      if ($urandom_range(0, 7) == 0) ad = $urandom;
      else ad = 32'($urandom_range(0, MW*4-1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom_range(0, 2), rd, er, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      tb_mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = tb_mem[i][8*b +: 8];
    end
    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'b0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'd0;
    bus.req_wdata_i    = 32'd0;
    bus.resp_ready_i   = 1'b0;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back(2'd2, 3);
    test_back_to_back(2'd3, 2);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
